tff_counter: RTL and testbench
==============================

TFF_COUNTER -- requirements
Module: tff_counter

Interface
REQ-001 Parameter WIDTH, default 8, sets register width in bits; legal range 2..32.
REQ-002 clk  input  1  Single clock; all state updates on its rising edge.
REQ-003 rst  input  1  Reset; synchronous, active-high.
REQ-004 en  input  1  Update enable; when low, q holds unless ld is high.
REQ-005 mode  input  2  Operation select: 00 toggle, 01 count up, 10 count down, 11 hold.
REQ-006 t  input  WIDTH  Per-bit toggle mask; used in toggle mode only.
REQ-007 ld  input  1  Synchronous load strobe.
REQ-008 ld_val  input  WIDTH  Load value.
REQ-009 clr_ovf  input  1  Clears sticky ovf.
REQ-010 q  output  WIDTH  Registered state.
REQ-011 qbar  output  WIDTH  Bitwise complement of q, combinational from q.
REQ-012 tc  output  1  Registered terminal-count pulse.
REQ-013 ovf  output  1  Sticky wrap/saturation flag.

Function
REQ-014 Update priority per rising edge SHALL be: rst, then ld, then en with mode, then hold.
REQ-015 ld=1 SHALL set q to ld_val regardless of en and mode, and SHALL drive tc to 0 that cycle.
REQ-016 In toggle mode with en=1, q SHALL become q XOR t; bits with t=0 hold; tc SHALL be 0.
REQ-017 In up mode with en=1, q SHALL become q+1 modulo 2^WIDTH.
REQ-018 In down mode with en=1, q SHALL become q-1 modulo 2^WIDTH.
REQ-019 In hold mode, or with en=0 and ld=0, q SHALL be unchanged and tc SHALL be 0.
REQ-020 tc SHALL be 1 for exactly the one cycle following an edge where q was all-ones in up mode, or all-zeros in down mode, with en=1 and ld=0; otherwise tc SHALL be 0.
REQ-021 ovf SHALL set on any edge that qualifies tc per REQ-020 and SHALL remain set until clr_ovf=1 or rst.
REQ-022 If clr_ovf=1 on the same edge as a tc-qualifying event, ovf SHALL end set (set wins).
REQ-023 Output latency SHALL be one clock from inputs to q, tc and ovf; qbar SHALL track q with zero latency.
REQ-024 A mode change SHALL take effect on the very next edge, with no pipeline state carried over.

Reset
REQ-025 On rst=1 at a rising edge, q SHALL become 0, qbar all-ones, tc 0 and ovf 0, overriding ld, en and clr_ovf.
REQ-026 rst asserted mid-count SHALL discard the count in progress, with no tc pulse generated on the reset edge.
REQ-027 After rst deasserts, the first edge SHALL process inputs normally.

Configuration
REQ-028 The macro TFF_COUNTER_SAT_EN SHALL select saturating behaviour when defined.
REQ-029 With TFF_COUNTER_SAT_EN defined, at the terminal value up mode SHALL hold at all-ones and down mode SHALL hold at all-zeros. tc and ovf SHALL still assert per REQ-020 and REQ-021 on each such attempt.
REQ-030 Without TFF_COUNTER_SAT_EN defined, counting SHALL wrap per REQ-017 and REQ-018.

Verification (WIDTH=4)
REQ-031 Reset: rst=1 with ld=1 and ld_val=0xA -> q=0x0, qbar=0xF, tc=0, ovf=0.
REQ-032 Toggle: q=0x5, mode=00, en=1, t=0x3 -> q=0x6; next edge with t=0x0 -> q=0x6.
REQ-033 Up-wrap: ld_val=0xE, then 2 up edges -> q=0xF then 0x0, with tc=1 for one cycle after the 0xF->0x0 edge and ovf=1. With the SAT macro, q=0xF holds and tc=1.
REQ-034 Down-wrap: q=0x0, mode=10, en=1 -> q=0xF, tc=1, ovf=1; apply clr_ovf alone -> ovf=0.
REQ-035 Priority and hold: ld=1, ld_val=0x3, en=1, mode=01 -> q=0x3 (not 0x4). Then en=0 for 3 cycles -> q=0x3 and tc=0 throughout.
REQ-036 Set/clear collision: q=0xF, mode=01, en=1, clr_ovf=1 on the same edge -> ovf=1. Then rst mid-count at q=0x7 -> q=0x0 and tc=0.

Source files
------------

// File: rtl/tff_counter.sv
// Loadable toggle / up / down register with a one-cycle terminal-count pulse and sticky overflow.
// Define TFF_COUNTER_SAT_EN to saturate at the terminal values instead of wrapping.
module tff_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] t,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc,
    output logic             ovf
);

    typedef enum logic [1:0] {
        MODE_TOGGLE = 2'b00,
        MODE_UP     = 2'b01,
        MODE_DOWN   = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ALL_ZEROS = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

    mode_e            mode_sel;
    logic             at_top;
    logic             at_bottom;
    logic             term_hit;
    logic [WIDTH-1:0] q_inc;
    logic [WIDTH-1:0] q_dec;
    logic [WIDTH-1:0] q_next;
    logic             tc_next;
    logic             ovf_next;

    assign mode_sel  = mode_e'(mode);
    assign at_top    = (q == ALL_ONES);
    assign at_bottom = (q == ALL_ZEROS);

    // A terminal event is a count attempt past the end of the range; loads pre-empt it.
    assign term_hit = en && !ld &&
                      (((mode_sel == MODE_UP) && at_top) ||
                       ((mode_sel == MODE_DOWN) && at_bottom));

`ifdef TFF_COUNTER_SAT_EN
    assign q_inc = at_top    ? q : q + ONE;
    assign q_dec = at_bottom ? q : q - ONE;
`else
    assign q_inc = q + ONE;
    assign q_dec = q - ONE;
`endif

    always_comb begin
        q_next = q;
        if (ld) begin
            q_next = ld_val;
        end else if (en) begin
            case (mode_sel)
                MODE_TOGGLE: q_next = q ^ t;
                MODE_UP:     q_next = q_inc;
                MODE_DOWN:   q_next = q_dec;
                MODE_HOLD:   q_next = q;
                default:     q_next = q;
            endcase
        end
    end

    // Setting ovf takes precedence over a simultaneous clear.
    always_comb begin
        tc_next  = term_hit;
        ovf_next = term_hit | (ovf & ~clr_ovf);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q   <= ALL_ZEROS;
            tc  <= 1'b0;
            ovf <= 1'b0;
        end else begin
            q   <= q_next;
            tc  <= tc_next;
            ovf <= ovf_next;
        end
    end

    assign qbar = ~q;

endmodule

// File: tb/tb_tff_counter.sv
// Self-checking bench for tff_counter at WIDTH=4: directed scenarios plus randomized traffic
// checked against an arithmetic reference model.
module tb_tff_counter;

    localparam int W = 4;
    localparam int MOD = 16;

    logic         clk;
    logic         rst;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] t;
    logic         ld;
    logic [W-1:0] ld_val;
    logic         clr_ovf;
    logic [W-1:0] q;
    logic [W-1:0] qbar;
    logic         tc;
    logic         ovf;

    int total = 0;
    int bad   = 0;

    int m_q   = 0;
    bit m_tc  = 0;
    bit m_ovf = 0;

`ifdef TFF_COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    tff_counter #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .mode    (mode),
        .t       (t),
        .ld      (ld),
        .ld_val  (ld_val),
        .clr_ovf (clr_ovf),
        .q       (q),
        .qbar    (qbar),
        .tc      (tc),
        .ovf     (ovf)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: integer arithmetic over 0..15 following the update rules.
    task automatic model_edge();
        int  nq;
        bit  hit;
        nq  = m_q;
        hit = 0;
        if (rst) begin
            m_q = 0; m_tc = 0; m_ovf = 0;
            return;
        end
        if (ld) begin
            nq = int'(ld_val);
        end else if (en) begin
            case (mode)
                2'b00: nq = m_q ^ int'(t);
                2'b01: begin
                    hit = (m_q == MOD - 1);
                    nq  = (SAT && hit) ? m_q : (m_q + 1) % MOD;
                end
                2'b10: begin
                    hit = (m_q == 0);
                    nq  = (SAT && hit) ? m_q : (m_q + MOD - 1) % MOD;
                end
                default: nq = m_q;
            endcase
        end
        m_q   = nq;
        m_tc  = hit;
        m_ovf = hit || (m_ovf && !clr_ovf);
    endtask

    // driver: advance one edge, then sample 1 time unit later
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; en = 0; mode = 2'b11; t = '0; ld = 0; ld_val = '0; clr_ovf = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; ld = 1; ld_val = 4'hA; en = 1; mode = 2'b01; clr_ovf = 0;
        step();
        step();
        total++;
        if (q !== 4'h0) begin bad++; $display("FAIL reset_q got=%h exp=0", q); end
        total++;
        if (qbar !== 4'hF) begin bad++; $display("FAIL reset_qbar got=%h exp=f", qbar); end
        total++;
        if (tc !== 1'b0 || ovf !== 1'b0) begin
            bad++; $display("FAIL reset_flags got tc=%b ovf=%b exp tc=0 ovf=0", tc, ovf);
        end
        idle_inputs();
    endtask

    task automatic test_toggle();
        ld = 1; ld_val = 4'h5; step(); ld = 0;
        en = 1; mode = 2'b00; t = 4'h3;
        step();
        total++;
        if (q !== 4'h6 || tc !== 1'b0) begin
            bad++; $display("FAIL toggle_xor got q=%h tc=%b exp q=6 tc=0", q, tc);
        end
        t = 4'h0;
        step();
        total++;
        if (q !== 4'h6) begin bad++; $display("FAIL toggle_zero_mask got=%h exp=6", q); end
        idle_inputs();
    endtask

    task automatic test_up_wrap();
        logic [W-1:0] exp_after;
        exp_after = SAT ? 4'hF : 4'h0;
        ld = 1; ld_val = 4'hE; step(); ld = 0;
        en = 1; mode = 2'b01;
        step();
        total++;
        if (q !== 4'hF || tc !== 1'b0) begin
            bad++; $display("FAIL up_to_top got q=%h tc=%b exp q=f tc=0", q, tc);
        end
        step();
        total++;
        if (q !== exp_after || tc !== 1'b1 || ovf !== 1'b1) begin
            bad++; $display("FAIL up_wrap got q=%h tc=%b ovf=%b exp q=%h tc=1 ovf=1",
                            q, tc, ovf, exp_after);
        end
        en = 0;
        step();
        total++;
        if (tc !== 1'b0 || ovf !== 1'b1) begin
            bad++; $display("FAIL up_tc_pulse_width got tc=%b ovf=%b exp tc=0 ovf=1", tc, ovf);
        end
        idle_inputs();
    endtask

    task automatic test_down_wrap();
        logic [W-1:0] exp_after;
        exp_after = SAT ? 4'h0 : 4'hF;
        clr_ovf = 1; ld = 1; ld_val = 4'h0; step();
        clr_ovf = 0; ld = 0;
        total++;
        if (ovf !== 1'b0) begin bad++; $display("FAIL clr_with_load got ovf=%b exp=0", ovf); end
        en = 1; mode = 2'b10;
        step();
        total++;
        if (q !== exp_after || tc !== 1'b1 || ovf !== 1'b1) begin
            bad++; $display("FAIL down_wrap got q=%h tc=%b ovf=%b exp q=%h tc=1 ovf=1",
                            q, tc, ovf, exp_after);
        end
        en = 0; clr_ovf = 1;
        step();
        total++;
        if (ovf !== 1'b0 || tc !== 1'b0 || q !== exp_after) begin
            bad++; $display("FAIL clr_ovf got q=%h tc=%b ovf=%b exp q=%h tc=0 ovf=0",
                            q, tc, ovf, exp_after);
        end
        idle_inputs();
    endtask

    task automatic test_priority_hold();
        ld = 1; ld_val = 4'h3; en = 1; mode = 2'b01;
        step();
        total++;
        if (q !== 4'h3 || tc !== 1'b0) begin
            bad++; $display("FAIL load_priority got q=%h tc=%b exp q=3 tc=0", q, tc);
        end
        ld = 0; en = 0;
        for (int i = 0; i < 3; i++) begin
            mode = 2'(i);
            step();
            total++;
            if (q !== 4'h3 || tc !== 1'b0) begin
                bad++; $display("FAIL hold_en_low cyc=%0d got q=%h tc=%b exp q=3 tc=0", i, q, tc);
            end
        end
        idle_inputs();
    endtask

    task automatic test_collision_reset();
        logic [W-1:0] exp_after;
        exp_after = SAT ? 4'hF : 4'h0;
        ld = 1; ld_val = 4'hF; step(); ld = 0;
        en = 1; mode = 2'b01; clr_ovf = 1;
        step();
        clr_ovf = 0;
        total++;
        if (ovf !== 1'b1 || tc !== 1'b1 || q !== exp_after) begin
            bad++; $display("FAIL set_beats_clear got q=%h tc=%b ovf=%b exp q=%h tc=1 ovf=1",
                            q, tc, ovf, exp_after);
        end
        ld = 1; ld_val = 4'h6; step(); ld = 0;
        step();
        total++;
        if (q !== 4'h7) begin bad++; $display("FAIL pre_reset_count got=%h exp=7", q); end
        rst = 1;
        step();
        total++;
        if (q !== 4'h0 || tc !== 1'b0 || ovf !== 1'b0) begin
            bad++; $display("FAIL mid_count_reset got q=%h tc=%b ovf=%b exp 0/0/0", q, tc, ovf);
        end
        rst = 0;
        step();
        total++;
        if (q !== 4'h1) begin bad++; $display("FAIL first_edge_after_reset got=%h exp=1", q); end
        idle_inputs();
    endtask

    // Randomized back-to-back traffic with mode changes every cycle.
    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst     = ($urandom_range(0, 39) == 0);
            ld      = ($urandom_range(0, 9) == 0);
            ld_val  = W'($urandom_range(0, MOD - 1));
            en      = ($urandom_range(0, 4) != 0);
            mode    = 2'($urandom_range(0, 3));
            t       = W'($urandom_range(0, MOD - 1));
            clr_ovf = ($urandom_range(0, 7) == 0);
            // steer toward the terminal values now and then
            if ($urandom_range(0, 5) == 0) begin
                ld = 1; ld_val = $urandom_range(0, 1) ? 4'hF : 4'h0;
            end
            step();
            total++;
            if (q !== W'(m_q) || qbar !== ~W'(m_q) || tc !== m_tc || ovf !== m_ovf) begin
                bad++;
                $display("FAIL random cyc=%0d got q=%h qbar=%h tc=%b ovf=%b exp q=%h qbar=%h tc=%b ovf=%b",
                         i, q, qbar, tc, ovf, W'(m_q), ~W'(m_q), m_tc, m_ovf);
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_toggle();
        test_up_wrap();
        test_down_wrap();
        test_priority_hold();
        test_collision_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
